fp_round_pipe: RTL and testbench

- Back-end rounding stage for fp_fma and fp_add; consumes their unrounded result and produces the final packed IEEE-754 result plus exception flags.
- Two-stage pipeline with a valid/ready handshake on both sides, so one rounder can be time-shared behind the arithmetic units.

---
 rtl/fp_round_pipe.sv | 187 ++++++++++++++++++
 tb/tb_fp_round_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage IEEE-754 rounding back end with valid/ready on both sides.
// Define FP_ROUND_FTZ_EN to flush subnormal results to signed zero.
package fp_pkg;
  typedef enum logic [1:0] {
    FP32,
    FP64,
    FP16,
    FP16ALT
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  function automatic int unsigned exp_bits(fp_format_e f);
    case (f)
      FP64:    return 11;
      FP16:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e f);
    case (f)
      FP64:    return 52;
      FP16:    return 10;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e f);
    return 1 + exp_bits(f) + man_bits(f);
  endfunction
endpackage

module fp_round_pipe
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int unsigned EXP_WIDTH = exp_bits(FP_FORMAT),
  localparam int unsigned MANT_WIDTH = man_bits(FP_FORMAT),
  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [FP_WIDTH+5:0] urnd_i,
  input  roundmode_e          rnd_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [FP_WIDTH-1:0] result_o,
  output logic [4:0]          fflags_o
);

  localparam int unsigned MAG = EXP_WIDTH + MANT_WIDTH;
  localparam logic [MAG-1:0] EXP_LSB =
    {{(EXP_WIDTH-1){1'b0}}, 1'b1, {MANT_WIDTH{1'b0}}};

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
  } fp_t;

  typedef struct packed {
    fp_t        u_result;
    logic [1:0] rs;
    logic       round_en;
    logic       invalid;
    logic [1:0] exp_cout;
  } urnd_t;

  logic       s1_valid;
  urnd_t      s1_u;
  roundmode_e s1_rnd;
  logic       s2_free;

  fp_t            ur;
  fp_t            res;
  logic [MAG-1:0] mag;
  logic [MAG:0]   sum;
  logic           rnd_on;
  logic           inexact;
  logic           inc;
  logic           to_inf;
  logic           top;
  logic           ovf;
  logic           nx;
  logic           uf;
  logic [4:0]     flags;

  assign s2_free    = ~out_valid_o | out_ready_i;
  assign in_ready_o = ~s1_valid | s2_free;

  always_comb begin
    ur      = s1_u.u_result;
    mag     = {ur.exp, ur.mant};
    rnd_on  = s1_u.round_en & ~s1_u.invalid;
    inexact = |s1_u.rs;
    inc     = 1'b0;
    to_inf  = 1'b0;
    unique case (s1_rnd)
      RNE: begin
        inc    = s1_u.rs[1] & (s1_u.rs[0] | ur.mant[0]);
        to_inf = 1'b1;
      end
      RDN: begin
        inc    = inexact & ur.sign;
        to_inf = ur.sign;
      end
      RUP: begin
        inc    = inexact & ~ur.sign;
        to_inf = ~ur.sign;
      end
      RMM: begin
        inc    = s1_u.rs[1];
        to_inf = 1'b1;
      end
      default: begin
        inc    = 1'b0;
        to_inf = 1'b0;
      end
    endcase
    sum = {1'b0, mag} + {{MAG{1'b0}}, inc};
    // an inexact max-finite magnitude is flagged whatever the mode
    top = &(mag | EXP_LSB);
    ovf = rnd_on & ((s1_u.exp_cout == 2'b01) | sum[MAG]
        | (&sum[MAG-1:MANT_WIDTH]) | (inexact & top));
    res   = ur;
    nx    = 1'b0;
    uf    = 1'b0;
    flags = {s1_u.invalid, 4'b0000};
    if (rnd_on) begin
      res = {ur.sign, sum[MAG-1:0]};
      if (ovf) begin
        if (to_inf)
          res = {ur.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        else
          res = {ur.sign, {{(EXP_WIDTH-1){1'b1}}, 1'b0},
                 {MANT_WIDTH{1'b1}}};
      end
      nx = inexact | ovf;
      uf = nx & (ur.exp == '0);
`ifdef FP_ROUND_FTZ_EN
      if ((res.exp == '0) && (res.mant != '0)) begin
        res.mant = '0;
        uf       = 1'b1;
        nx       = 1'b1;
      end
`endif
      flags = {2'b00, ovf, uf, nx};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid    <= 1'b0;
      s1_u        <= '0;
      s1_rnd      <= RNE;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      fflags_o    <= '0;
    end else begin
      if (s2_free) begin
        out_valid_o <= s1_valid;
        if (s1_valid) begin
          result_o <= res;
          fflags_o <= flags;
        end
      end
      if (in_ready_o) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) begin
          s1_u   <= urnd_t'(urnd_i);
          s1_rnd <= rnd_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: directed and random checks of fp_round_pipe (FP32)
// against an arithmetic reference model and a result scoreboard.
module tb_fp_round_pipe;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [37:0] urnd;
  roundmode_e  rnd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_round_pipe #(.FP_FORMAT(FP32)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .urnd_i     (urnd),
    .rnd_i      (rnd),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .fflags_o   (fflags)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [37:0] mk(input logic s, input logic [7:0] e,
      input logic [22:0] m, input logic [1:0] rs, input logic ren,
      input logic inv, input logic [1:0] co);
    return {s, e, m, rs, ren, inv, co};
  endfunction

  // reference: value-level rounding of a 31-bit magnitude, returns {result, flags}
  function automatic logic [36:0] model(input logic [37:0] u,
                                        input roundmode_e md);
    logic        s;
    int unsigned e;
    int unsigned mag;
    int unsigned nm;
    logic [1:0]  rs;
    logic [1:0]  co;
    logic        lost, up, ovf, inf, nx, uf;
    logic [31:0] r;
    s   = u[37];
    e   = {24'd0, u[36:29]};
    mag = {1'b0, u[36:6]};
    rs  = u[5:4];
    co  = u[1:0];
    if (!u[3] || u[2]) return {u[37:6], u[2], 4'b0000};
    lost = (rs != 2'b00);
    up   = 1'b0;
    case (md)
      RNE: up = rs[1] && (rs[0] || (mag % 2 == 1));
      RDN: up = lost && s;
      RUP: up = lost && !s;
      RMM: up = rs[1];
      default: up = 1'b0;
    endcase
    inf = (md == RNE) || (md == RMM) || (md == RUP && !s) || (md == RDN && s);
    nm  = mag + {31'd0, up};
    ovf = (co == 2'b01) || (nm / (1 << 23) >= 255)
       || (lost && ((mag + 1) / (1 << 23) >= 255));
    nx  = lost || ovf;
    uf  = nx && (e == 0);
    if (ovf) r = {s, inf ? 31'h7F800000 : 31'h7F7FFFFF};
    else     r = {s, nm[30:0]};
`ifdef FP_ROUND_FTZ_EN
    if (!ovf && r[30:23] == 8'd0 && r[22:0] != 23'd0) begin
      r  = {s, 31'd0};
      uf = 1'b1;
      nx = 1'b1;
    end
`endif
    return {r, 1'b0, 1'b0, ovf, uf, nx};
  endfunction

  function automatic logic [37:0] rand_beat();
    logic [7:0]  e;
    logic [22:0] m;
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: e = 8'h00;
      1: e = 8'hFE;
      2: e = 8'h7F;
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
    return mk(1'($urandom_range(0, 1)), e, m, 2'($urandom_range(0, 3)),
              $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
              ($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00);
  endfunction

  task automatic run_one(input string tag, input logic [37:0] u,
      input roundmode_e md, input logic [31:0] er, input logic [4:0] ef);
    urnd     = u;
    rnd      = md;
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".lat"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, ".vld"}, 64'(out_valid), 64'd1);
    chk({tag, ".res"}, 64'(result), 64'(er));
    chk({tag, ".flg"}, 64'(fflags), 64'(ef));
    @(posedge clk); #1;
  endtask

  task automatic stream(input int nbeats, input bit rmode);
    logic [36:0] q[$];
    logic [36:0] hold_v;
    logic [36:0] expv;
    logic [37:0] cur;
    roundmode_e  cm;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit held = 0;
    bit saw_block = 0;
    bit acc;
    cur      = rand_beat();
    cm       = roundmode_e'(3'($urandom_range(0, 4)));
    urnd     = cur;
    rnd      = cm;
    in_valid = 1'b1;
    while ((sent < nbeats || q.size() != 0 || out_valid) && cyc < 2000) begin
      if (rmode) begin
        out_ready = ($urandom_range(0, 2) != 0);
        if (!in_valid && sent < nbeats)
          in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = !(cyc >= 3 && cyc <= 5);
      end
      @(negedge clk);
      if (held) begin
        chk("hold.vld", 64'(out_valid), 64'd1);
        chk("hold.val", 64'({result, fflags}), 64'(hold_v));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra.out", 64'(out_valid), 64'd0);
        end else begin
          expv = q.pop_front();
          chk("stream.res", 64'({result, fflags}), 64'(expv));
          got++;
        end
      end
      held   = out_valid && !out_ready;
      hold_v = {result, fflags};
      acc    = in_valid && in_ready;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (acc) begin
        q.push_back(model(cur, cm));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (sent < nbeats) begin
          cur      = rand_beat();
          cm       = roundmode_e'(3'($urandom_range(0, 4)));
          urnd     = cur;
          rnd      = cm;
          in_valid = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream.count", 64'(got), 64'(nbeats));
    if (!rmode) chk("stream.block", 64'(saw_block), 64'd1);
  endtask

  initial begin
    logic [31:0] ftz_rdn;
    logic [31:0] ftz_rtz;
`ifdef FP_ROUND_FTZ_EN
    ftz_rdn = 32'h80000000;
    ftz_rtz = 32'h80000000;
`else
    ftz_rdn = 32'h80000002;
    ftz_rtz = 32'h80000001;
`endif
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    urnd      = '0;
    rnd       = RNE;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset.vld", 64'(out_valid), 64'd0);
    chk("reset.res", 64'(result), 64'd0);
    chk("reset.flg", 64'(fflags), 64'd0);
    chk("reset.rdy", 64'(in_ready), 64'd1);

    run_one("rne_carry", mk(1'b0, 8'h7F, 23'h7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00),
            RNE, 32'h40000000, 5'b00001);
    run_one("ovf_rne", mk(1'b0, 8'hFE, 23'h7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00),
            RNE, 32'h7F800000, 5'b00101);
    run_one("ovf_rtz", mk(1'b0, 8'hFE, 23'h7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00),
            RTZ, 32'h7F7FFFFF, 5'b00101);
    run_one("sub_rdn", mk(1'b1, 8'h00, 23'h000001, 2'b01, 1'b1, 1'b0, 2'b00),
            RDN, ftz_rdn, 5'b00011);
    run_one("sub_rtz", mk(1'b1, 8'h00, 23'h000001, 2'b01, 1'b1, 1'b0, 2'b00),
            RTZ, ftz_rtz, 5'b00011);
    run_one("nan_pass", mk(1'b0, 8'hFF, 23'h400000, 2'b00, 1'b0, 1'b1, 2'b00),
            RNE, 32'h7FC00000, 5'b10000);
    run_one("exact_pass", mk(1'b0, 8'h7F, 23'h000000, 2'b11, 1'b0, 1'b0, 2'b00),
            RNE, 32'h3F800000, 5'b00000);
    run_one("inv_ren", mk(1'b0, 8'hFF, 23'h400000, 2'b11, 1'b1, 1'b1, 2'b00),
            RUP, 32'h7FC00000, 5'b10000);
    run_one("sub_norm", mk(1'b0, 8'h00, 23'h7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00),
            RNE, 32'h00800000, 5'b00011);
    run_one("ovf_rup_neg", mk(1'b1, 8'hFE, 23'h7FFFFF, 2'b01, 1'b1, 1'b0, 2'b00),
            RUP, 32'hFF7FFFFF, 5'b00101);
    run_one("cout_ovf", mk(1'b0, 8'h10, 23'h000000, 2'b00, 1'b1, 1'b0, 2'b01),
            RTZ, 32'h7F7FFFFF, 5'b00101);
    run_one("rmm_tie", mk(1'b0, 8'h7F, 23'h000002, 2'b10, 1'b1, 1'b0, 2'b00),
            RMM, 32'h3F800003, 5'b00001);
    run_one("rne_tie_even", mk(1'b0, 8'h7F, 23'h000002, 2'b10, 1'b1, 1'b0, 2'b00),
            RNE, 32'h3F800002, 5'b00001);

    stream(4, 1'b0);
    stream(300, 1'b1);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    urnd      = rand_beat();
    @(posedge clk); #1;
    urnd = rand_beat();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flight.vld", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    chk("rst2.vld", 64'(out_valid), 64'd0);
    chk("rst2.res", 64'(result), 64'd0);
    chk("rst2.flg", 64'(fflags), 64'd0);
    chk("rst2.rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst2.stale", 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
